// File: rtl/vdp_mem_pkg.sv
// Shared memory-access types and lane helpers for the VDP memory clients.
package vdp_mem_pkg;

  typedef enum logic [1:0] {
    MEM_W8  = 2'b00,
    MEM_W16 = 2'b01,
    MEM_W32 = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_REFRESH = 2'd3
  } arb_state_t;

  // Encoding 11 is folded into the 32-bit case.
  function automatic mem_size_t decode_size(input logic [1:0] size);
    mem_size_t sz;
    case (size)
      2'b00:   sz = MEM_W8;
      2'b01:   sz = MEM_W16;
      default: sz = MEM_W32;
    endcase
    return sz;
  endfunction

  // Replicate LSB-aligned write data across every lane it may land on.
  function automatic logic [31:0] steer_data(input mem_size_t sz, input logic [31:0] wdata);
    logic [31:0] d;
    case (sz)
      MEM_W8:  d = {4{wdata[7:0]}};
      MEM_W16: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Byte mask: a set bit means that byte is left untouched.
  function automatic logic [3:0] steer_mask(input mem_size_t sz, input logic [1:0] lane);
    logic [3:0] m;
    case (sz)
      MEM_W8:  m = ~(4'b0001 << lane);
      MEM_W16: m = lane[1] ? 4'b0011 : 4'b1100;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pull the addressed byte/half/word out of a core word, zero-extended.
  function automatic logic [31:0] extract_rdata(input mem_size_t sz, input logic [1:0] lane,
                                                input logic [31:0] dout);
    logic [31:0] r;
    case (sz)
      MEM_W8:  r = {24'h000000, dout[{lane, 3'b000} +: 8]};
      MEM_W16: r = lane[1] ? {16'h0000, dout[31:16]} : {16'h0000, dout[15:0]};
      default: r = dout;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from just after the last winner.
module rr_arbiter #(
  parameter int WIDTH = 3,
  parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] grant,
  output logic [PTR_W-1:0] last_ptr
);

  logic [PTR_W-1:0] last_r;
  logic [PTR_W-1:0] grant_idx_s;
  logic [WIDTH-1:0] grant_s;
  logic             found_s;
  int               idx_s;

  // Walk one full turn starting at last+1; the first requester wins.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = last_r;
    found_s     = 1'b0;
    idx_s       = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      idx_s = int'(last_r) + i;
      if (idx_s >= WIDTH) begin
        idx_s = idx_s - WIDTH;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_idx_s    = PTR_W'(idx_s);
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Remember the winner only when the grant is actually taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_r <= '0;
    end else if (advance) begin
      last_r <= grant_idx_s;
    end
  end

  assign grant    = grant_s;
  assign last_ptr = last_r;

endmodule

// File: rtl/vram_port_arbiter.sv
// Multi-port SDRAM front-end: fixed-priority port 0, round-robin for the rest,
// self-scheduled auto-refresh, lane steering and read extraction.
module vram_port_arbiter
  import vdp_mem_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int OP_CYCLES      = 4,
  parameter int REFRESH_CYCLES = 405
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    we,
  input  logic [2*NUM_PORTS-1:0]  size,
  input  logic [23*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]    ack,
  output logic [NUM_PORTS-1:0]    rvalid,
  output logic [32*NUM_PORTS-1:0] rdata,
  output logic [20:0]             core_addr,
  output logic                    core_rd,
  output logic                    core_wr,
  output logic                    core_refresh,
  output logic [31:0]             core_din,
  output logic [3:0]              core_wdm,
  input  logic [31:0]             core_dout,
  input  logic                    core_busy,
  input  logic                    core_data_ready,
  output logic                    enabled,
  output logic                    fail
);

  localparam int GW     = NUM_PORTS - 1;
  localparam int PIW    = $clog2(NUM_PORTS);
  localparam int GPW    = (GW > 1) ? $clog2(GW) : 1;
  localparam int OCW    = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam int RCW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  arb_state_t             state_r, state_next_s;
  logic [OCW-1:0]         op_cnt_r;
  logic                   op_last_s;
  logic [RCW-1:0]         ref_cnt_r;
  logic                   ref_wrap_s;
  logic                   refresh_pending_r;
  logic                   do_grant_s, do_refresh_s, rr_advance_s;
  logic [PIW-1:0]         grant_port_s, group_port_s;
  logic [GW-1:0]          rr_grant_s;
  logic [GPW-1:0]         rr_last_unused_s;
  mem_size_t              sel_size_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [DATA_W-1:0]      sel_wdata_s;

  logic [NUM_PORTS-1:0]   ack_r, rvalid_r;
  logic [32*NUM_PORTS-1:0] rdata_r;
  logic [20:0]            core_addr_r;
  logic                   core_rd_r, core_wr_r, core_refresh_r;
  logic [31:0]            core_din_r;
  logic [3:0]             core_wdm_r;
  logic                   enabled_r, fail_r;
  logic [PIW-1:0]         cur_port_r;
  mem_size_t              cur_size_r;
  logic [1:0]             cur_lane_r;
  logic                   cur_we_r;

  rr_arbiter #(.WIDTH(GW), .PTR_W(GPW)) u_rr (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req[NUM_PORTS-1:1]),
    .advance  (rr_advance_s),
    .grant    (rr_grant_s),
    .last_ptr (rr_last_unused_s)
  );

  // Convert the group one-hot grant into a full port index.
  always_comb begin
    group_port_s = '0;
    for (int i = 0; i < GW; i++) begin
      if (rr_grant_s[i]) begin
        group_port_s = PIW'(i + 1);
      end else begin
        group_port_s = group_port_s;
      end
    end
  end

  assign sel_size_s  = decode_size(size[grant_port_s*2 +: 2]);
  assign sel_addr_s  = addr[grant_port_s*ADDR_W +: ADDR_W];
  assign sel_wdata_s = wdata[grant_port_s*DATA_W +: DATA_W];
  assign op_last_s   = (op_cnt_r == OCW'(OP_CYCLES - 1));
  assign ref_wrap_s  = (state_r != ST_INIT) && (ref_cnt_r == RCW'(REFRESH_CYCLES - 1));

  // Next-state and arbitration decision: refresh, then port 0, then round-robin.
  always_comb begin
    state_next_s = state_r;
    do_grant_s   = 1'b0;
    do_refresh_s = 1'b0;
    rr_advance_s = 1'b0;
    grant_port_s = '0;
    case (state_r)
      ST_INIT: begin
        if (!core_busy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (refresh_pending_r) begin
          do_refresh_s = 1'b1;
          state_next_s = ST_REFRESH;
        end else if (req[0]) begin
          do_grant_s   = 1'b1;
          state_next_s = ST_ACCESS;
        end else if (|rr_grant_s) begin
          do_grant_s   = 1'b1;
          rr_advance_s = 1'b1;
          grant_port_s = group_port_s;
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS, ST_REFRESH: begin
        if (op_last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operation length counter for ACCESS and REFRESH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_cnt_r <= '0;
    end else if (do_grant_s || do_refresh_s) begin
      op_cnt_r <= '0;
    end else if (state_r == ST_ACCESS || state_r == ST_REFRESH) begin
      op_cnt_r <= op_cnt_r + OCW'(1);
    end else begin
      op_cnt_r <= '0;
    end
  end

  // Refresh timer; a wrap in the same cycle as a refresh keeps the new request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ref_cnt_r         <= '0;
      refresh_pending_r <= 1'b0;
    end else begin
      if (state_r == ST_INIT || ref_wrap_s) begin
        ref_cnt_r <= '0;
      end else begin
        ref_cnt_r <= ref_cnt_r + RCW'(1);
      end
      if (ref_wrap_s) begin
        refresh_pending_r <= 1'b1;
      end else if (do_refresh_s) begin
        refresh_pending_r <= 1'b0;
      end
    end
  end

  // Grant capture, core command strobes, read completion and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_r          <= '0;
      rvalid_r       <= '0;
      rdata_r        <= '0;
      core_addr_r    <= '0;
      core_rd_r      <= 1'b0;
      core_wr_r      <= 1'b0;
      core_refresh_r <= 1'b0;
      core_din_r     <= '0;
      core_wdm_r     <= '0;
      enabled_r      <= 1'b0;
      fail_r         <= 1'b0;
      cur_port_r     <= '0;
      cur_size_r     <= MEM_W32;
      cur_lane_r     <= 2'b00;
      cur_we_r       <= 1'b0;
    end else begin
      ack_r          <= '0;
      rvalid_r       <= '0;
      core_rd_r      <= 1'b0;
      core_wr_r      <= 1'b0;
      core_refresh_r <= do_refresh_s;
      if (state_r == ST_INIT && !core_busy) begin
        enabled_r <= 1'b1;
      end
      if (do_grant_s) begin
        ack_r[grant_port_s] <= 1'b1;
        cur_port_r  <= grant_port_s;
        cur_size_r  <= sel_size_s;
        cur_lane_r  <= sel_addr_s[1:0];
        cur_we_r    <= we[grant_port_s];
        core_addr_r <= sel_addr_s[22:2];
        core_din_r  <= steer_data(sel_size_s, sel_wdata_s);
        core_wdm_r  <= steer_mask(sel_size_s, sel_addr_s[1:0]);
        core_rd_r   <= ~we[grant_port_s];
        core_wr_r   <= we[grant_port_s];
      end
      if (state_r == ST_ACCESS && op_last_s && !cur_we_r) begin
        rdata_r[cur_port_r*DATA_W +: DATA_W] <= extract_rdata(cur_size_r, cur_lane_r, core_dout);
        rvalid_r[cur_port_r] <= 1'b1;
        if (!core_data_ready) begin
          fail_r <= 1'b1;
        end
      end
    end
  end

  assign ack          = ack_r;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;
  assign core_addr    = core_addr_r;
  assign core_rd      = core_rd_r;
  assign core_wr      = core_wr_r;
  assign core_refresh = core_refresh_r;
  assign core_din     = core_din_r;
  assign core_wdm     = core_wdm_r;
  assign enabled      = enabled_r;
  assign fail         = fail_r;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter.
module tb_vram_port_arbiter;

  localparam int NP  = 4;
  localparam int OPC = 4;
  localparam int RC  = 405;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NP-1:0]   req, we;
  logic [2*NP-1:0] size;
  logic [23*NP-1:0] addr;
  logic [32*NP-1:0] wdata;
  logic [NP-1:0]   ack, rvalid;
  logic [32*NP-1:0] rdata;
  logic [20:0]     core_addr;
  logic            core_rd, core_wr, core_refresh;
  logic [31:0]     core_din;
  logic [3:0]      core_wdm;
  logic [31:0]     core_dout;
  logic            core_busy, core_data_ready;
  logic            enabled, fail;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  vram_port_arbiter #(.NUM_PORTS(NP), .OP_CYCLES(OPC), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .ack(ack), .rvalid(rvalid), .rdata(rdata), .core_addr(core_addr),
    .core_rd(core_rd), .core_wr(core_wr), .core_refresh(core_refresh),
    .core_din(core_din), .core_wdm(core_wdm), .core_dout(core_dout),
    .core_busy(core_busy), .core_data_ready(core_data_ready),
    .enabled(enabled), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                          input logic [22:0] a, input logic [31:0] d);
    we[p]            = w;
    size[p*2 +: 2]   = sz;
    addr[p*23 +: 23] = a;
    wdata[p*32 +: 32] = d;
  endtask

  // Issue one request and wait (bounded) for its ack; t is the ack cycle.
  task automatic do_req(input int p, input logic w, input logic [1:0] sz,
                        input logic [22:0] a, input logic [31:0] d, output int t);
    bit hit = 1'b0;
    t = -1;
    set_port(p, w, sz, a, d);
    req[p] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ack[p]) begin
        hit = 1'b1;
        t = cyc;
        break;
      end
    end
    req[p] = 1'b0;
    check_val($sformatf("ack_seen_p%0d", p), {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_rvalid(input int p, output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rvalid[p]) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ref(output int t);
    t = -1;
    for (int i = 0; i < 2 * RC + 20; i++) begin
      step();
      if (core_refresh) begin
        t = cyc;
        break;
      end
    end
    check_val("refresh_seen", {31'd0, (t >= 0)}, 32'd1);
  endtask

  initial begin
    int t, tr, cnt, got, exp, ra, rb, rcy, t3, t0;
    resetn = 1'b0; req = '0; we = '0; size = '0; addr = '0; wdata = '0;
    core_dout = 32'h0; core_busy = 1'b1; core_data_ready = 1'b1;
    repeat (3) step();

    // Reset values
    check_val("rst_enabled", {31'd0, enabled}, 32'd0);
    check_val("rst_fail", {31'd0, fail}, 32'd0);
    check_val("rst_ack_rvalid", {24'd0, ack, rvalid}, 32'd0);
    check_val("rst_core_addr", {11'd0, core_addr}, 32'd0);
    check_val("rst_core_din", core_din, 32'd0);
    check_val("rst_strobes_wdm", {25'd0, core_rd, core_wr, core_refresh, core_wdm}, 32'd0);
    check_val("rst_rdata", {31'd0, |rdata}, 32'd0);

    // Busy core for 20 cycles with port 0 requesting: no grants.
    resetn = 1'b1;
    set_port(0, 1'b0, 2'b10, 23'h0, 32'h0);
    req[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (|ack || enabled) cnt++;
    end
    core_busy = 1'b0;
    step();
    check_val("init_enabled_next", {31'd0, enabled}, 32'd1);
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (|ack) cnt++;
    end
    check_val("init_no_ack", cnt, 32'd0);

    // Port 2: 8-bit write of 0x5A at byte 3
    do_req(2, 1'b1, 2'b00, 23'h000003, 32'h0000005A, t);
    check_val("w8_core_wr", {30'd0, core_wr, core_rd}, 32'd2);
    check_val("w8_core_addr", {11'd0, core_addr}, 32'd0);
    check_val("w8_core_din", core_din, 32'h5A5A5A5A);
    check_val("w8_core_wdm", {28'd0, core_wdm}, 32'h7);
    cnt = 0;
    for (int i = 0; i < OPC + 2; i++) begin
      step();
      if (ack[2]) cnt++;
      if (i == OPC - 2) check_val("w8_stable", {core_wdm, core_din[27:0]}, 32'h7A5A5A5A);
    end
    check_val("w8_ack_once", cnt, 32'd0);

    // Port 0: 16-bit write 0xCAFE at byte 2 (upper half)
    do_req(0, 1'b1, 2'b01, 23'h000002, 32'h1234CAFE, t);
    check_val("w16_core_din", core_din, 32'hCAFECAFE);
    check_val("w16_core_wdm", {28'd0, core_wdm}, 32'h3);
    repeat (OPC) step();

    // Port 1: 16-bit read at 0x6
    core_dout = 32'hBEEF1234;
    do_req(1, 1'b0, 2'b01, 23'h000006, 32'h0, t);
    check_val("r16_core_rd", {30'd0, core_wr, core_rd}, 32'd1);
    check_val("r16_core_addr", {11'd0, core_addr}, 32'd1);
    wait_rvalid(1, tr);
    check_val("r16_latency", tr - t, OPC);
    check_val("r16_rdata", rdata[63:32], 32'h0000BEEF);
    step();
    check_val("r16_rvalid_pulse", {31'd0, rvalid[1]}, 32'd0);

    // Port 3: 8-bit read lane 1; port 0: 32-bit read with ignored lane bits
    do_req(3, 1'b0, 2'b00, 23'h000011, 32'h0, t);
    wait_rvalid(3, tr);
    check_val("r8_rdata", rdata[127:96], 32'h00000012);
    do_req(0, 1'b0, 2'b11, 23'h000007, 32'h0, t);
    check_val("r32_core_addr", {11'd0, core_addr}, 32'd1);
    wait_rvalid(0, tr);
    check_val("r32_rdata", rdata[31:0], 32'hBEEF1234);
    check_val("r_fail_clear", {31'd0, fail}, 32'd0);

    // Priority and round-robin (last group winner was port 3)
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 2'b10, 23'(p * 4), 32'h0);
    req = 4'hF;
    for (int n = 0; n < 18; n++) begin
      got = -1;
      for (int i = 0; i < 50; i++) begin
        step();
        if (|ack) begin
          got = onehot_idx(ack);
          break;
        end
      end
      if (n == 11) req[0] = 1'b0;
      exp = (n < 12) ? 0 : ((n - 12) % 3) + 1;
      check_val($sformatf("rr_grant_%0d", n), got, exp);
    end
    req = '0;

    // Refresh period while idle
    wait_ref(ra);
    wait_ref(rb);
    wait_ref(rcy);
    check_val("ref_period", rcy - rb, RC);

    // Timer wraps during port 3 ACCESS; refresh beats a waiting port 0
    t3 = rcy + RC - 3;
    while (cyc < t3 - 1) step();
    set_port(3, 1'b0, 2'b10, 23'h000040, 32'h0);
    req[3] = 1'b1;
    step();
    check_val("rf_ack3_cycle", {31'd0, ack[3]}, 32'd1);
    req[3] = 1'b0;
    set_port(0, 1'b0, 2'b10, 23'h000044, 32'h0);
    req[0] = 1'b1;
    wait_ref(ra);
    check_val("rf_after_access", ra - t3, OPC + 1);
    t0 = -1;
    for (int i = 0; i < 50; i++) begin
      if (ack[0]) begin
        t0 = cyc;
        break;
      end
      step();
    end
    req[0] = 1'b0;
    check_val("rf_then_port0", t0 - ra, OPC + 1);

    // Missing data-ready sets sticky fail
    core_data_ready = 1'b0;
    do_req(1, 1'b0, 2'b10, 23'h000010, 32'h0, t);
    wait_rvalid(1, tr);
    step();
    check_val("fail_set", {31'd0, fail}, 32'd1);
    core_data_ready = 1'b1;
    core_dout = 32'h89ABCDEF;
    do_req(2, 1'b0, 2'b10, 23'h000020, 32'h0, t);
    wait_rvalid(2, tr);
    check_val("fail_good_rdata", rdata[95:64], 32'h89ABCDEF);
    step();
    check_val("fail_sticky", {31'd0, fail}, 32'd1);

    // Reset during an in-flight read aborts it
    do_req(1, 1'b0, 2'b10, 23'h000030, 32'h0, t);
    step();
    resetn = 1'b0;
    #1;
    check_val("abort_fail_clr", {31'd0, fail}, 32'd0);
    check_val("abort_rdata_clr", {31'd0, |rdata}, 32'd0);
    step();
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < OPC + 4; i++) begin
      step();
      if (|rvalid) cnt++;
    end
    check_val("abort_no_rvalid", cnt, 32'd0);
    check_val("abort_reenabled", {31'd0, enabled}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Multi-port front-end for the on-chip SDRAM core. It generalises the single-requester memory controller to `NUM_PORTS` independent request channels, each with its own 8/16/32-bit access width. It also schedules its own auto-refresh, so requesters never issue refresh. It sits between the VDP clients (renderer, command engine, CPU port, …) and the `sdram` core, and owns lane steering, write masks, read-data extraction and the timing-failure check.

## Interface
Parameters:
- `NUM_PORTS`, 4: request channels; port 0 is fixed highest priority.
- `OP_CYCLES`, 4: cycles from core command to completion (read data sampled).
- `REFRESH_CYCLES`, 405: refresh period in `clk` cycles (7.5 µs at 54 MHz).

Ports:
- `clk`  in  1: logic clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_PORTS: per-port request; held until `ack`.
- `we`  in  NUM_PORTS: 1 = write, 0 = read.
- `size`  in  2×NUM_PORTS: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = treated as 32-bit.
- `addr`  in  23×NUM_PORTS: byte address.
- `wdata`  in  32×NUM_PORTS: write data, LSB-aligned.
- `ack`  out  NUM_PORTS: one-cycle pulse when the request is captured.
- `rvalid`  out  NUM_PORTS: one-cycle pulse when read data is valid.
- `rdata`  out  32×NUM_PORTS: LSB-aligned read data, held until that port's next read completes.
- `core_addr`  out  21: 32-bit word address, `addr[22:2]`.
- `core_rd`, `core_wr`, `core_refresh`  out  1 each: one-cycle core command strobes.
- `core_din`  out  32: lane-steered write data.
- `core_wdm`  out  4: byte mask; 1 = byte not written.
- `core_dout`  in  32: core read data.
- `core_busy`  in  1: core busy (high during initialisation).
- `core_data_ready`  in  1: core read-data-valid flag.
- `enabled`  out  1: initialisation complete.
- `fail`  out  1: sticky timing-failure flag.

## Operation
- States: INIT, IDLE, ACCESS, REFRESH.
- INIT (reset state):
  - Wait for `core_busy` = 0, then go to IDLE and set `enabled` = 1.
  - No grants are issued in INIT.
  - The refresh timer is held at 0.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 while not in INIT.
  - On wrap it sets `refresh_pending`. A second wrap while already pending has no further effect.
- Arbitration in IDLE, in priority order:
  1. `refresh_pending`: pulse `core_refresh`, clear pending, go to REFRESH.
  2. `req[0]`.
  3. `req[1..N-1]`, round-robin, starting after the last granted port in that group.
- On a port grant:
  - Pulse `ack[p]`.
  - Register addr, size, we and steered data.
  - Issue `core_rd` or `core_wr` with `core_addr`/`core_din`/`core_wdm` stable until the op completes.
  - Go to ACCESS.
- Lane steering, with lane = `addr[1:0]`:
  - 8-bit: data replicated ×4; `core_wdm` = ~(0001 << lane).
  - 16-bit: data replicated ×2; `core_wdm` = `addr[1]` ? 0011 : 1100.
  - 32-bit: `core_wdm` = 0000; `addr[1:0]` ignored.
- Read extraction, zero-extended:
  - 8-bit: byte[lane].
  - 16-bit: half[`addr[1]`].
  - 32-bit: full word.
- ACCESS and REFRESH both last OP_CYCLES cycles, then return to IDLE.
- At the final ACCESS cycle of a read:
  - Latch the extracted data into `rdata[p]` and pulse `rvalid[p]`.
  - If `core_data_ready` = 0, set `fail` = 1. `fail` clears only on reset.
- Reset mid-operation aborts immediately. No `rvalid` is issued for an in-flight read.

## Timing
- Reset values:
  - `ack`, `rvalid`, `rdata`, `core_*` strobes, `core_din`, `core_wdm`, `core_addr`, `enabled`, `fail`: all 0.
  - Refresh timer and round-robin pointer: 0.
- With the grant edge as T:
  - `ack` is high in cycle T.
  - The core strobe is high in cycle T (registered together with `ack`).
  - `rvalid` is high in cycle T+OP_CYCLES.
  - The next grant is possible in cycle T+OP_CYCLES+1.
- Back-to-back throughput: one access per OP_CYCLES+1 cycles.
- Requesters must keep `req`/`addr`/`wdata` stable until `ack`. After `ack` they may change them, or drop `req` in the following cycle.
- A requester that keeps `req` high after `ack` is treated as issuing a new request.

## Structure
- Package `vdp_mem_pkg`:
  - `mem_size_t` enum (MEM_W8/W16/W32), matching the existing `MEMORY_WIDTH_*` encodings.
  - `arb_state_t` enum.
  - Lane-steer and extract functions, shared with the command engine.
- Sub-module `rr_arbiter`, parametrised by width: request vector, advance strobe, one-hot grant, last-grant pointer. It is instantiated for ports 1..N-1.

## Test plan
- Reset release with `core_busy` held high for 20 cycles -> `enabled` rises one cycle after `core_busy` falls; no `ack` before that.
- Port 2 writes 8-bit 0x5A at addr 0x000003 -> `core_addr` = 0, `core_din` = 0x5A5A5A5A, `core_wdm` = 0111, `ack[2]` pulses once.
- Port 1 reads 16-bit at 0x000006 with `core_dout` = 0xBEEF1234 -> `rdata[1]` = 0x0000BEEF, `rvalid[1]` exactly OP_CYCLES cycles after `ack[1]`.
- `req` held high on ports 0, 1, 2, 3 for 12 grants -> grant order 0 repeatedly; with port 0 dropped, order is 1, 2, 3, 1, …
- Refresh timer wraps while port 3 is in ACCESS -> refresh issued at the next IDLE, ahead of a pending `req[0]`; exactly one `core_refresh` per REFRESH_CYCLES.
- Read with `core_data_ready` forced 0 -> `fail` = 1 and stays 1 through later good reads; clears only on `resetn` low.
